// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings and constants shared by the instruction fetch stage.
package cpu_pkg;

    // Fetch-stage FSM states.
    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_FETCH = 2'b01,
        IF_DONE  = 2'b10,
        IF_ERR   = 2'b11
    } if_state_t;

    // Error codes reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } if_err_t;

    // Instruction word presented before the first fetch completes.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction addresses must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts FETCH cycles spent waiting for imem_ack and flags the
// last permitted cycle. Counts 0..TIMEOUT-1 and never wraps.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam int            TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    // Wait counter: synchronous reset, clear has priority over count.
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == TC);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC-update unit and instruction memory.
// Requests the word at PC, registers it as Instr, and releases the PC unit
// (stall=0) for exactly one cycle per completed fetch. Misaligned PCs and
// imem timeouts park the stage in a sticky error state until reset.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr,
    output logic [31:0] fetch_count
);
    if_state_t   r_state;
    if_state_t   w_next_state;
    if_err_t     r_err_code;
    logic [31:0] r_instr;
    logic [31:0] r_err_addr;
    logic [31:0] r_fetch_count;

    logic w_in_fetch;
    logic w_aligned;
    logic w_misalign;
    logic w_fetch_done;
    logic w_timeout;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_tc;

    assign w_in_fetch   = (r_state == IF_FETCH);
    assign w_aligned    = is_word_aligned(PC[1:0]);
    assign w_misalign   = w_in_fetch && !w_aligned;
    // Only an acknowledged, aligned request in FETCH completes a fetch.
    assign w_fetch_done = w_in_fetch && w_aligned && imem_ack;
    // An ack in the terminal cycle wins over the timeout.
    assign w_timeout    = w_in_fetch && w_aligned && !imem_ack && w_timer_tc;

    // The timer only runs while waiting; any other state leaves it at zero,
    // and it stops at the terminal count instead of wrapping.
    assign w_timer_clear = !w_in_fetch;
    assign w_timer_en    = w_in_fetch && w_aligned && !imem_ack && !w_timer_tc;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .CLK        (CLK),
        .reset      (reset),
        .i_clear    (w_timer_clear),
        .i_enable   (w_timer_en),
        .o_terminal (w_timer_tc)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: errors are checked before completion; ERR is sticky.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IF_IDLE:  w_next_state = IF_FETCH;
            IF_FETCH: begin
                if (w_misalign || w_timeout) begin
                    w_next_state = IF_ERR;
                end else if (w_fetch_done) begin
                    w_next_state = IF_DONE;
                end
            end
            IF_DONE:  w_next_state = IF_FETCH;
            IF_ERR:   w_next_state = IF_ERR;
            default:  w_next_state = IF_IDLE;
        endcase
    end

    // Output decode: the PC unit is held everywhere except DONE.
    always_comb begin
        imem_req    = 1'b0;
        stall       = 1'b1;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        case (r_state)
            IF_FETCH: imem_req = w_aligned;
            IF_DONE: begin
                stall       = 1'b0;
                instr_valid = 1'b1;
            end
            IF_ERR:   fetch_err = 1'b1;
            default:  ;
        endcase
    end

    // Address goes out only alongside a request, so it is always aligned.
    assign imem_addr = imem_req ? PC : 32'h0;

    // Instruction register and completed-fetch counter (wraps naturally).
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_instr       <= RESET_INSTR;
            r_fetch_count <= 32'h0;
        end else if (w_fetch_done) begin
            r_instr       <= imem_rdata;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Error capture: the code and the offending PC are latched on entry to ERR.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_err_code <= ERR_NONE;
            r_err_addr <= 32'h0;
        end else if (w_misalign) begin
            r_err_code <= ERR_MISALIGN;
            r_err_addr <= PC;
        end else if (w_timeout) begin
            r_err_code <= ERR_TIMEOUT;
            r_err_addr <= PC;
        end
    end

    assign Instr       = r_instr;
    assign fetch_count = r_fetch_count;
    assign err_code    = r_err_code;
    assign err_addr    = r_err_addr;

endmodule
